// File: rtl/irq_responder.sv
// CPU-side interrupt responder: takes intc requests at instruction boundaries,
// redirects the PC to the ISR vector, runs the 4-phase IACK handshake and handles ERET.
module irq_responder #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8,
  parameter bit RESET_IE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq,
  input  logic [31:0]      iaddr,
  output logic             iack,
  input  logic [31:0]      pc_next,
  input  logic             pc_en,
  input  logic             eret,
  input  logic             ie_wr,
  input  logic             ie_wd,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic [31:0]      epc,
  output logic             in_isr,
  output logic             ie,
  output logic             ack_timeout,
  output logic [CNT_W-1:0] irq_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACK, SERVICE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_iack, w_iack_nxt;
  logic [31:0]      r_epc, w_epc_nxt;
  logic             r_in_isr, w_in_isr_nxt;
  logic             r_ie, w_ie_nxt;
  logic             r_to, w_to_nxt;
  logic [CNT_W-1:0] r_irq_cnt, w_irq_cnt_nxt;
  logic [TW-1:0]    r_tcnt, w_tcnt_nxt;
  logic             w_take, w_ret;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_take = (r_state == IDLE) && irq && r_ie && pc_en;
  assign w_ret  = (r_state == SERVICE) && eret && pc_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_iack    <= 1'b0;
      r_epc     <= '0;
      r_in_isr  <= 1'b0;
      r_ie      <= RESET_IE;
      r_to      <= 1'b0;
      r_irq_cnt <= '0;
      r_tcnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_iack    <= w_iack_nxt;
      r_epc     <= w_epc_nxt;
      r_in_isr  <= w_in_isr_nxt;
      r_ie      <= w_ie_nxt;
      r_to      <= w_to_nxt;
      r_irq_cnt <= w_irq_cnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_iack_nxt    = r_iack;
    w_epc_nxt     = r_epc;
    w_in_isr_nxt  = r_in_isr;
    w_ie_nxt      = r_ie;
    w_to_nxt      = r_to;
    w_irq_cnt_nxt = r_irq_cnt;
    w_tcnt_nxt    = r_tcnt;
    pc_redirect   = 1'b0;
    pc_target     = r_epc;

    // Lowest-priority ie source; take and return below override it.
    if (ie_wr) w_ie_nxt = ie_wd;

    case (r_state)
      IDLE: begin
        if (w_take) begin
          pc_redirect   = 1'b1;
          pc_target     = iaddr;
          w_epc_nxt     = pc_next;
          w_ie_nxt      = 1'b0;
          w_in_isr_nxt  = 1'b1;
          w_irq_cnt_nxt = sat_inc(r_irq_cnt);
          w_iack_nxt    = 1'b1;
          w_tcnt_nxt    = '0;
          w_state_nxt   = ACK;
        end
      end
      ACK: begin
        w_tcnt_nxt = r_tcnt + TW'(1);
        if (!irq) begin
          w_iack_nxt  = 1'b0;
          w_state_nxt = SERVICE;
        end else if (r_tcnt == TO_LAST) begin
          w_iack_nxt  = 1'b0;
          w_to_nxt    = 1'b1;
          w_state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (w_ret) begin
          pc_redirect  = 1'b1;
          w_ie_nxt     = 1'b1;
          w_in_isr_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // The CPU must never be redirected while the core is held in reset.
    if (!rst) begin
      pc_redirect = 1'b0;
      pc_target   = '0;
    end
  end

  assign iack        = r_iack;
  assign epc         = r_epc;
  assign in_isr      = r_in_isr;
  assign ie          = r_ie;
  assign ack_timeout = r_to;
  assign irq_count   = r_irq_cnt;

endmodule
